// File: rtl/vga_scanout_pkg.sv
// Shared VGA 640x480@60 timing constants, framebuffer geometry and pixel types
// used by the scanout pipeline and its timing generator.
package vga_scanout_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_TOTAL   = 800;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_TOTAL   = 525;

    localparam int FB_W_DEFAULT       = 160;
    localparam int FB_H_DEFAULT       = 120;
    localparam int SCALE_LOG2_DEFAULT = 2;

    // Read-port address width of the dual-port RAM is DUALPORT_BITSREQ + 1.
    localparam int DUALPORT_BITSREQ = 14;
    localparam int DUALPORT_SIZE    = FB_W_DEFAULT * FB_H_DEFAULT;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } scan_flags_t;

    localparam scan_flags_t FLAGS_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic rgb332_t to_rgb332(input logic [7:0] px);
        return rgb332_t'(px);
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the scanout (master) and the dual-port RAM (slave).
interface vga_scanout_if
    import vga_scanout_pkg::*;
#(
    parameter int ADDR_W = DUALPORT_BITSREQ + 1
) ();

    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;

    modport master (output r_en, output r_addr, input r_data);
    modport slave  (input r_en, input r_addr, output r_data);

endinterface

// File: rtl/vga_scanout_timing.sv
// Stage-0 raster timing: h/v counters, visible/sync regions and the registered
// vertical-blank / frame-tick indications for the CPU side.
module vga_timing
    import vga_scanout_pkg::*;
#(
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_TOTAL    = VGA_H_TOTAL,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_TOTAL    = VGA_V_TOTAL,
    parameter int SCALE_LOG2 = SCALE_LOG2_DEFAULT,
    localparam int HCW       = $clog2(H_TOTAL)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [HCW-1:0] h_cnt,
    output logic           active,
    output logic           hs_raw,
    output logic           vs_raw,
    output logic           frame_end,
    output logic           row_end,
    output logic           vblank,
    output logic           frame_tick
);

    localparam int VCW = $clog2(V_TOTAL);

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_VIS_C  = HCW'(H_VISIBLE);
    localparam logic [HCW-1:0] HS_START = HCW'(H_VISIBLE + H_FP);
    localparam logic [HCW-1:0] HS_END   = HCW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_VIS_C  = VCW'(V_VISIBLE);
    localparam logic [VCW-1:0] VS_START = VCW'(V_VISIBLE + V_FP);
    localparam logic [VCW-1:0] VS_END   = VCW'(V_VISIBLE + V_FP + V_SYNC);

    logic [VCW-1:0] v_cnt;
    logic           line_end;

    assign active    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign hs_raw    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);
    // Last replicated screen line of a framebuffer row: the fetch line base moves on.
    assign row_end   = line_end && (&v_cnt[SCALE_LOG2-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            vblank     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vblank     <= (v_cnt >= V_VIS_C);
            frame_tick <= (h_cnt == '0) && (v_cnt == V_VIS_C);
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// Scans a 160x120x8bpp framebuffer out as 4x-replicated 640x480@60 VGA, with a
// fixed 3-clock counter-to-pin latency shared by colour and both syncs.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int FB_W       = FB_W_DEFAULT,
    parameter int FB_H       = FB_H_DEFAULT,
    parameter int SCALE_LOG2 = SCALE_LOG2_DEFAULT,
    parameter int ADDR_W     = DUALPORT_BITSREQ + 1,
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_TOTAL    = VGA_H_TOTAL,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_TOTAL    = VGA_V_TOTAL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_scanout_if.master        fb,
    output logic [2:0]           vga_r,
    output logic [2:0]           vga_g,
    output logic [1:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vblank,
    output logic                 frame_tick
);

    localparam int HCW = $clog2(H_TOTAL);
    localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((FB_H - 1) * FB_W);

    logic [HCW-1:0]    h_cnt;
    logic              active;
    logic              hs_raw;
    logic              vs_raw;
    logic              frame_end;
    logic              row_end;
    logic [ADDR_W-1:0] line_base;
    scan_flags_t       s0_flags;
    scan_flags_t       s1_flags;
    scan_flags_t       s2_flags;
    rgb332_t           pixel;

    vga_timing #(
        .H_VISIBLE  (H_VISIBLE),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_TOTAL    (H_TOTAL),
        .V_VISIBLE  (V_VISIBLE),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_TOTAL    (V_TOTAL),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .active     (active),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .frame_end  (frame_end),
        .row_end    (row_end),
        .vblank     (vblank),
        .frame_tick (frame_tick)
    );

    assign s0_flags = '{active: active, hs: hs_raw, vs: vs_raw};

    // line_base tracks (v_cnt >> SCALE_LOG2) * FB_W without a multiplier; it
    // stops at the last row so blanking lines never push it past the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base <= '0;
            fb.r_en   <= 1'b0;
            fb.r_addr <= '0;
        end else begin
            fb.r_en <= active;
            if (active) begin
                fb.r_addr <= line_base + ADDR_W'(h_cnt >> SCALE_LOG2);
            end
            if (frame_end) begin
                line_base <= '0;
            end else if (row_end && (line_base != LAST_BASE)) begin
                line_base <= line_base + FB_W_A;
            end
        end
    end

    // Flags ride alongside the RAM read so the colour gate and the syncs land
    // on the pins in the same cycle as the pixel they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_flags <= FLAGS_IDLE;
            s2_flags <= FLAGS_IDLE;
            pixel    <= '0;
            vga_hs   <= 1'b1;
            vga_vs   <= 1'b1;
        end else begin
            s1_flags <= s0_flags;
            s2_flags <= s1_flags;
            pixel    <= s2_flags.active ? to_rgb332(fb.r_data) : '0;
            vga_hs   <= s2_flags.hs;
            vga_vs   <= s2_flags.vs;
        end
    end

    assign vga_r = pixel.r;
    assign vga_g = pixel.g;
    assign vga_b = pixel.b;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench: full-size scanout checked against directed per-cycle vectors,
// plus a reduced-geometry instance for frame-level timing within a short run.
module tb_vga_scanout;
    import vga_scanout_pkg::*;

    typedef enum int {F_REN, F_ADDR, F_RGB, F_HS, F_VS} fld_e;
    typedef struct {
        int   cyc;
        fld_e fld;
        int   val;
    } exp_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rst_n_s = 1'b0;
    int   cyc     = 0;
    int   cyc_s   = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    bit   small_done = 1'b0;
    exp_t exp_q[$];

    logic [2:0] vga_r, vga_g, s_vga_r, s_vga_g;
    logic [1:0] vga_b, s_vga_b;
    logic       vga_hs, vga_vs, vblank, frame_tick;
    logic       s_vga_hs, s_vga_vs, s_vblank, s_frame_tick;

    vga_scanout_if #(.ADDR_W(15)) fb ();
    vga_scanout_if #(.ADDR_W(15)) fb_s ();

    always #20 clk = ~clk;

    vga_scanout dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fb         (fb),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vblank     (vblank),
        .frame_tick (frame_tick)
    );

    // 8x6 buffer on a 48x30 raster: one frame is 1440 clocks.
    vga_scanout #(
        .FB_W(8), .FB_H(6), .SCALE_LOG2(2), .ADDR_W(15),
        .H_VISIBLE(32), .H_FP(4), .H_SYNC(8), .H_TOTAL(48),
        .V_VISIBLE(24), .V_FP(2), .V_SYNC(2), .V_TOTAL(30)
    ) dut_small (
        .clk        (clk),
        .rst_n      (rst_n_s),
        .fb         (fb_s),
        .vga_r      (s_vga_r),
        .vga_g      (s_vga_g),
        .vga_b      (s_vga_b),
        .vga_hs     (s_vga_hs),
        .vga_vs     (s_vga_vs),
        .vblank     (s_vblank),
        .frame_tick (s_frame_tick)
    );

    // RAM models: byte = ~addr, and 0xFF whenever no read is issued.
    always @(posedge clk) fb.r_data   <= fb.r_en   ? ~fb.r_addr[7:0]   : 8'hFF;
    always @(posedge clk) fb_s.r_data <= fb_s.r_en ? ~fb_s.r_addr[7:0] : 8'hFF;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic expect_at(input int c, input fld_e f, input int v);
        exp_t e;
        e.cyc = c;
        e.fld = f;
        e.val = v;
        exp_q.push_back(e);
    endtask

    function automatic int actual_of(input fld_e f);
        case (f)
            F_REN:   return int'(fb.r_en);
            F_ADDR:  return int'(fb.r_addr);
            F_RGB:   return int'({vga_r, vga_g, vga_b});
            F_HS:    return int'(vga_hs);
            F_VS:    return int'(vga_vs);
            default: return -1;
        endcase
    endfunction

    task automatic check_reset(input string p);
        check_output({p, "_ren"},   int'(fb.r_en), 0);
        check_output({p, "_addr"},  int'(fb.r_addr), 0);
        check_output({p, "_rgb"},   int'({vga_r, vga_g, vga_b}), 0);
        check_output({p, "_hs"},    int'(vga_hs), 1);
        check_output({p, "_vs"},    int'(vga_vs), 1);
        check_output({p, "_vblank"}, int'(vblank), 0);
        check_output({p, "_tick"},  int'(frame_tick), 0);
    endtask

    // Cycle k = k-th rising edge after reset release; fetch reflects raster
    // position k-1, pins reflect position k-3.
    task automatic apply_stimulus();
        expect_at(1,    F_REN,  1);
        expect_at(1,    F_ADDR, 0);
        expect_at(2,    F_RGB,  0);
        expect_at(3,    F_RGB,  255);
        expect_at(4,    F_ADDR, 0);
        expect_at(5,    F_ADDR, 1);
        expect_at(6,    F_RGB,  255);
        expect_at(7,    F_RGB,  254);
        expect_at(9,    F_ADDR, 2);
        expect_at(640,  F_REN,  1);
        expect_at(640,  F_ADDR, 159);
        expect_at(641,  F_REN,  0);
        expect_at(641,  F_ADDR, 159);
        expect_at(642,  F_RGB,  96);
        expect_at(643,  F_RGB,  0);
        expect_at(658,  F_HS,   1);
        expect_at(659,  F_HS,   0);
        expect_at(700,  F_RGB,  0);
        expect_at(754,  F_HS,   0);
        expect_at(755,  F_HS,   1);
        expect_at(800,  F_REN,  0);
        expect_at(801,  F_REN,  1);
        expect_at(801,  F_ADDR, 0);
        expect_at(803,  F_RGB,  255);
        expect_at(3201, F_ADDR, 160);
        expect_at(3203, F_RGB,  95);
        expect_at(3205, F_ADDR, 161);
        expect_at(3840, F_ADDR, 319);
        expect_at(3841, F_REN,  0);
        expect_at(4000, F_VS,   1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc != cyc)
                    check_output($sformatf("late_c%0d", e.cyc), cyc, e.cyc);
                else
                    check_output($sformatf("c%0d_%s", e.cyc, e.fld.name()),
                                 actual_of(e.fld), e.val);
            end
        end
    end

    initial begin : full_driver
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        apply_stimulus();
        rst_n = 1'b1;
        for (int i = 0; i < 6000 && cyc != 4300; i++) @(negedge clk);
        check_output("reach_h300_v5", cyc, 4300);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        repeat (5) @(posedge clk);
        expect_at(1, F_REN,  1);
        expect_at(1, F_ADDR, 0);
        expect_at(2, F_RGB,  0);
        expect_at(3, F_RGB,  255);
        expect_at(5, F_ADDR, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check_output("sb_drained", exp_q.size(), 0);
        for (int i = 0; i < 10000 && !small_done; i++) @(negedge clk);
        check_output("small_done", int'(small_done), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : small_driver
        int vb_cnt, ren_cnt, vs_cnt, tick_cnt, first_tick, last_tick;
        int first_vb, max_addr, addr_last;
        vb_cnt = 0; ren_cnt = 0; vs_cnt = 0; tick_cnt = 0;
        first_tick = 0; last_tick = 0; first_vb = 0; max_addr = 0; addr_last = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_s = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (k <= 2592 && s_vblank) begin
                vb_cnt++;
                if (first_vb == 0) first_vb = k;
            end
            if (k <= 1440 && fb_s.r_en) ren_cnt++;
            if (k <= 1440 && !s_vga_vs) vs_cnt++;
            if (s_frame_tick) begin
                tick_cnt++;
                if (first_tick == 0) first_tick = k;
                last_tick = k;
            end
            if (int'(fb_s.r_addr) > max_addr) max_addr = int'(fb_s.r_addr);
            if (k == 1136) addr_last = int'(fb_s.r_addr);
        end
        check_output("s_ren_per_frame", ren_cnt, 768);
        check_output("s_vs_low_clocks", vs_cnt, 96);
        check_output("s_vblank_clocks", vb_cnt, 288);
        check_output("s_vblank_rise", first_vb, 1153);
        check_output("s_tick_first", first_tick, 1153);
        check_output("s_tick_period", last_tick - first_tick, 1440);
        check_output("s_tick_high_clocks", tick_cnt, 2);
        check_output("s_addr_last_pixel", addr_last, 47);
        check_output("s_addr_max", max_addr, 47);
        small_done = 1'b1;
    end

endmodule
